// File: rtl/cim_xbar_tile.sv
// Behavioural CIM crossbar tile: binary weight array, per-row activation buffer,
// row-serial column dot-products scaled by 1/xbar_size, registered result read port.
module cim_xbar_tile #(
  parameter int xbar_size     = 128,
  parameter int datatype_size = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr_en,
  input  logic [$clog2(xbar_size)-1:0] i_wr_addr,
  input  logic [datatype_size-1:0]     i_wr_data,
  input  logic                         i_w_we,
  input  logic [$clog2(xbar_size)-1:0] i_w_row,
  input  logic [xbar_size-1:0]         i_w_data,
  input  logic                         i_start,
  output logic                         o_busy,
  output logic                         o_done,
  input  logic [$clog2(xbar_size)-1:0] i_rd_addr,
  output logic [datatype_size-1:0]     o_rd_data
);

  localparam int aw   = $clog2(xbar_size);
  localparam int accw = datatype_size + aw;

  typedef enum logic {
    IDLE,
    COMPUTE
  } state_t;

  state_t state;
  logic [aw-1:0] row_cnt;

  logic [datatype_size-1:0] ibuf [xbar_size];
  logic [xbar_size-1:0]     w    [xbar_size];
  logic [accw-1:0]          acc  [xbar_size];
  logic [accw-1:0]          acc_next [xbar_size];
  logic [datatype_size-1:0] res  [xbar_size];

  // A write coinciding with start must not disturb the run that start launches,
  // so it is parked here and committed to the arrays when that run retires.
  logic                     pend_wr_valid;
  logic [aw-1:0]            pend_wr_addr;
  logic [datatype_size-1:0] pend_wr_data;
  logic                     pend_w_valid;
  logic [aw-1:0]            pend_w_row;
  logic [xbar_size-1:0]     pend_w_data;

  always_comb begin
    for (int c = 0; c < xbar_size; c++) begin
      acc_next[c] = acc[c] + (w[row_cnt][c] ? accw'(ibuf[row_cnt]) : accw'(0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      row_cnt       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_rd_data     <= '0;
      pend_wr_valid <= 1'b0;
      pend_wr_addr  <= '0;
      pend_wr_data  <= '0;
      pend_w_valid  <= 1'b0;
      pend_w_row    <= '0;
      pend_w_data   <= '0;
      for (int i = 0; i < xbar_size; i++) begin
        ibuf[i] <= '0;
        w[i]    <= '0;
        acc[i]  <= '0;
        res[i]  <= '0;
      end
    end else begin
      o_done    <= 1'b0;
      o_rd_data <= res[i_rd_addr];
      case (state)
        IDLE: begin
          if (i_start) begin
            state         <= COMPUTE;
            o_busy        <= 1'b1;
            row_cnt       <= '0;
            pend_wr_valid <= i_wr_en;
            pend_wr_addr  <= i_wr_addr;
            pend_wr_data  <= i_wr_data;
            pend_w_valid  <= i_w_we;
            pend_w_row    <= i_w_row;
            pend_w_data   <= i_w_data;
            for (int c = 0; c < xbar_size; c++) begin
              acc[c] <= '0;
            end
          end else begin
            if (i_wr_en) begin
              ibuf[i_wr_addr] <= i_wr_data;
            end
            if (i_w_we) begin
              w[i_w_row] <= i_w_data;
            end
          end
        end
        COMPUTE: begin
          row_cnt <= row_cnt + aw'(1);
          for (int c = 0; c < xbar_size; c++) begin
            acc[c] <= acc_next[c];
          end
          // Last row: publish the scaled sums (including this row) and retire parked writes.
          if (row_cnt == aw'(xbar_size - 1)) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
            for (int c = 0; c < xbar_size; c++) begin
              res[c] <= datatype_size'(acc_next[c] >> aw);
            end
            if (pend_wr_valid) begin
              ibuf[pend_wr_addr] <= pend_wr_data;
            end
            if (pend_w_valid) begin
              w[pend_w_row] <= pend_w_data;
            end
            pend_wr_valid <= 1'b0;
            pend_w_valid  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_xbar_tile.sv
// Directed self-checking bench for cim_xbar_tile at xbar_size=8, datatype_size=4.
module tb_cim_xbar_tile;

  localparam int xs = 8;
  localparam int dw = 4;

  typedef int exp_t [xs];

  logic          clk = 1'b0;
  logic          rst;
  logic          i_wr_en;
  logic [2:0]    i_wr_addr;
  logic [dw-1:0] i_wr_data;
  logic          i_w_we;
  logic [2:0]    i_w_row;
  logic [xs-1:0] i_w_data;
  logic          i_start;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    i_rd_addr;
  logic [dw-1:0] o_rd_data;

  int tests  = 0;
  int failed = 0;

  cim_xbar_tile #(.xbar_size(xs), .datatype_size(dw)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_w_we    (i_w_we),
    .i_w_row   (i_w_row),
    .i_w_data  (i_w_data),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ibuf(input int a, input int d);
    i_wr_en   = 1'b1;
    i_wr_addr = 3'(a);
    i_wr_data = dw'(d);
    tick();
    i_wr_en   = 1'b0;
  endtask

  task automatic write_w(input int r, input logic [xs-1:0] d);
    i_w_we   = 1'b1;
    i_w_row  = 3'(r);
    i_w_data = d;
    tick();
    i_w_we   = 1'b0;
  endtask

  task automatic check_cols(input string tag, input exp_t e);
    for (int c = 0; c < xs; c++) begin
      i_rd_addr = 3'(c);
      tick();
      check($sformatf("%s col%0d", tag, c), 32'(o_rd_data), e[c]);
    end
  endtask

  // Starts a run and returns in the o_done cycle; optionally pokes start/writes mid-run.
  task automatic run(input string tag, input bit disturb, input int rd_col, input int rd_exp);
    int cycles;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_wr_en = 1'b0;
    i_w_we  = 1'b0;
    check({tag, " busy after start"}, 32'(o_busy), 1);
    cycles    = 0;
    i_rd_addr = 3'(rd_col);
    while (o_busy === 1'b1 && cycles < 40) begin
      if (disturb && cycles == 2) begin
        i_start   = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_addr = 3'd0;
        i_wr_data = '0;
        i_w_we    = 1'b1;
        i_w_row   = 3'd0;
        i_w_data  = '0;
      end
      tick();
      cycles++;
      i_start = 1'b0;
      i_wr_en = 1'b0;
      i_w_we  = 1'b0;
      if (cycles == 4) begin
        check({tag, " read during busy"}, 32'(o_rd_data), rd_exp);
      end
    end
    check({tag, " busy cycles"}, 32'(cycles), 8);
    check({tag, " done pulse"}, 32'(o_done), 1);
  endtask

  initial begin
    rst       = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_w_we    = 1'b0;
    i_w_row   = '0;
    i_w_data  = '0;
    i_start   = 1'b0;
    i_rd_addr = '0;

    #12;
    check("reset busy", 32'(o_busy), 0);
    check("reset done", 32'(o_done), 0);
    check("reset rd_data", 32'(o_rd_data), 0);
    tick();
    rst = 1'b0;
    check_cols("reset", '{0, 0, 0, 0, 0, 0, 0, 0});

    // All ones, full-scale activations: 8*15 = 120, >>3 = 15.
    for (int r = 0; r < xs; r++) begin
      write_w(r, 8'hFF);
      write_ibuf(r, 15);
    end
    run("full", 1'b0, 0, 0);
    tick();
    check("full done drops", 32'(o_done), 0);
    check_cols("full", '{15, 15, 15, 15, 15, 15, 15, 15});

    // Single cell (0,0) with 15: col0 = 15>>3 = 1.
    write_w(0, 8'h01);
    for (int r = 1; r < xs; r++) begin
      write_w(r, 8'h00);
      write_ibuf(r, 0);
    end
    run("single", 1'b0, 0, 15);
    check_cols("single", '{1, 0, 0, 0, 0, 0, 0, 0});

    // Diagonal weights, activations 8: each column 8>>3 = 1.
    for (int r = 0; r < xs; r++) begin
      write_w(r, 8'(1 << r));
      write_ibuf(r, 8);
    end
    run("diag", 1'b0, 1, 0);
    check_cols("diag", '{1, 1, 1, 1, 1, 1, 1, 1});

    // Ibuf 9,1..7 under all-ones weights: 37>>3 = 4 (would be 3 if the mid-run writes took).
    for (int r = 0; r < xs; r++) begin
      write_w(r, 8'hFF);
      write_ibuf(r, (r == 0) ? 9 : r);
    end
    run("disturb", 1'b1, 3, 1);
    check_cols("disturb", '{4, 4, 4, 4, 4, 4, 4, 4});

    // Reset in the middle of a run.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("abort busy before rst", 32'(o_busy), 1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(o_busy), 0);
    check("abort done", 32'(o_done), 0);
    check("abort rd_data", 32'(o_rd_data), 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort no done", 32'(o_done), 0);
    check_cols("abort", '{0, 0, 0, 0, 0, 0, 0, 0});
    for (int r = 0; r < xs; r++) begin
      write_w(r, 8'hFF);
      write_ibuf(r, 15);
    end
    run("fresh", 1'b0, 2, 0);
    check_cols("fresh", '{15, 15, 15, 15, 15, 15, 15, 15});

    // Back-to-back: restart in the done cycle with a same-cycle ibuf[0]=1 write.
    for (int r = 0; r < xs; r++) begin
      write_ibuf(r, (r == 0) ? 9 : r);
    end
    run("b2b first", 1'b0, 5, 15);
    i_wr_en   = 1'b1;
    i_wr_addr = 3'd0;
    i_wr_data = 4'd1;
    run("b2b second", 1'b0, 5, 4);
    tick();
    check("b2b done drops", 32'(o_done), 0);
    check_cols("b2b second", '{4, 4, 4, 4, 4, 4, 4, 4});
    // Parked write now visible: 1+1+..+7 = 29, >>3 = 3.
    run("after park", 1'b0, 6, 4);
    check_cols("after park", '{3, 3, 3, 3, 3, 3, 3, 3});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
